scaler_vline_stepper: RTL and testbench

//  Consumer of the vertical scaler configuration (first read line, lines needed/full, lines out, interp

---
 rtl/scaler_vline_stepper_pkg.sv | 20 ++
 rtl/scaler_vstep_mult.sv | 32 +++
 rtl/scaler_vline_stepper.sv | 193 +++++++++++++++++++
 tb/tb_scaler_vline_stepper.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scaler_vline_stepper_pkg.sv
// Shared definitions for the vertical line stepper: phase-accumulator geometry,
// line/config field widths and the stepper state encoding.
package scaler_vline_stepper_pkg;

  localparam int unsigned FACTOR_W  = 18;  // 2^17 / vlines_out
  localparam int unsigned WEIGHT_W  = 8;   // blend weight width
  localparam int unsigned ACC_W     = 30;  // signed phase accumulator
  localparam int unsigned FRAC_BITS = 17;  // fractional bits of the accumulator
  localparam int unsigned LINE_W    = 10;  // input line numbers / needed count
  localparam int unsigned OUT_W     = 11;  // output line count
  localparam int unsigned STEP_W    = FACTOR_W + LINE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/scaler_vstep_mult.sv
// Registered unsigned multiply: p_o <= a_i * b_i when en is high, held otherwise.
// Intended to map onto a single DSP multiplier.
// Ports: clk, rst (sync, active high), en, a_i, b_i, p_o.
module scaler_vstep_mult
  import scaler_vline_stepper_pkg::*;
#(
  parameter int unsigned A_W = FACTOR_W,
  parameter int unsigned B_W = LINE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [A_W-1:0]     a_i,
  input  logic [B_W-1:0]     b_i,
  output logic [A_W+B_W-1:0] p_o
);

  logic [A_W+B_W-1:0] p_q, p_d;

  always_comb begin
    p_d = p_q;
    if (en) p_d = a_i * b_i;
  end

  always_ff @(posedge clk) begin
    if (rst) p_q <= '0;
    else     p_q <= p_d;
  end

  assign p_o = p_q;

endmodule

// File: rtl/scaler_vline_stepper.sv
// Vertical scaler line stepper. Shadows the vertical scaler config at each frame
// start and, for every requested active output line, names the two adjacent input
// lines to blend (a above, b below, b clamped to the last needed line) and the
// weight of b taken from the phase accumulator fraction.
// Ports:
//   VCLK, VRST           output video clock, synchronous active-high reset
//   vpos_1st_rdline_i    first input line to read
//   vlines_in_needed_i   input lines spanned by the active output
//   vlines_out_i         active output lines per frame
//   v_interp_factor_i    2^17 / vlines_out
//   v_allow_slemu_i      scanline emulation permitted
//   frame_start_i        pulse: shadow config and restart
//   line_req_i           pulse: next output line requested
//   line_vld_o           pulse one cycle after an accepted request
//   rdline_a_o/_b_o      upper/lower input line, weight_b_o weight of b
//   slemu_o              shadowed slemu flag
//   frame_done_o         all lines issued this frame
//   busy_o               config being shadowed / step being computed
// Build option: define SCALER_VSTEP_CENTER_EN to centre the sample grid
// (acc starts at (step - 2^17) >>> 1 instead of 0).
module scaler_vline_stepper
  import scaler_vline_stepper_pkg::*;
(
  input  logic                VCLK,
  input  logic                VRST,
  input  logic [LINE_W-1:0]   vpos_1st_rdline_i,
  input  logic [LINE_W-1:0]   vlines_in_needed_i,
  input  logic [OUT_W-1:0]    vlines_out_i,
  input  logic [FACTOR_W-1:0] v_interp_factor_i,
  input  logic                v_allow_slemu_i,
  input  logic                frame_start_i,
  input  logic                line_req_i,
  output logic                line_vld_o,
  output logic [LINE_W-1:0]   rdline_a_o,
  output logic [LINE_W-1:0]   rdline_b_o,
  output logic [WEIGHT_W-1:0] weight_b_o,
  output logic                slemu_o,
  output logic                frame_done_o,
  output logic                busy_o
);

  localparam int unsigned INT_W  = ACC_W - FRAC_BITS;
  localparam int unsigned WIDE_W = INT_W + 1;

  state_e                   state_q, state_d;
  logic                     calc_ph_q, calc_ph_d;
  logic [LINE_W-1:0]        first_q, first_d;
  logic [LINE_W-1:0]        needed_q, needed_d;
  logic [OUT_W-1:0]         out_q, out_d;
  logic                     slemu_q, slemu_d;
  logic [OUT_W-1:0]         count_q, count_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     vld_q, vld_d;
  logic [LINE_W-1:0]        a_q, a_d;
  logic [LINE_W-1:0]        b_q, b_d;
  logic [WEIGHT_W-1:0]      w_q, w_d;

  logic [STEP_W-1:0]        step;
  logic signed [ACC_W-1:0]  step_s;
  logic signed [ACC_W-1:0]  acc_init;
  logic                     mult_en;
  logic [INT_W-1:0]         line_int;
  logic [WIDE_W-1:0]        a_wide, b_cand, last_line;

  // The product is captured from the same inputs as the shadow registers in the
  // first CALC cycle, so it is settled when the accumulator is seeded in the second.
  assign mult_en = (state_q == ST_CALC) && !calc_ph_q;

  scaler_vstep_mult #(
    .A_W (FACTOR_W),
    .B_W (LINE_W)
  ) u_mult (
    .clk (VCLK),
    .rst (VRST),
    .en  (mult_en),
    .a_i (v_interp_factor_i),
    .b_i (vlines_in_needed_i),
    .p_o (step)
  );

  assign step_s = {{(ACC_W-STEP_W){1'b0}}, step};

`ifdef SCALER_VSTEP_CENTER_EN
  localparam logic signed [ACC_W-1:0] FRAC_ONE = ACC_W'(1) << FRAC_BITS;
  logic signed [ACC_W-1:0] acc_diff;
  assign acc_diff = step_s - FRAC_ONE;
  assign acc_init = acc_diff >>> 1;
`else
  assign acc_init = '0;
`endif

  // Integer part is only used when acc is non-negative, so it is unsigned here.
  assign line_int  = acc_q[ACC_W-1:FRAC_BITS];
  assign a_wide    = WIDE_W'(first_q) + WIDE_W'(line_int);
  assign b_cand    = a_wide + WIDE_W'(1);
  assign last_line = WIDE_W'(first_q) + WIDE_W'(needed_q) - WIDE_W'(1);

  always_comb begin
    state_d   = state_q;
    calc_ph_d = calc_ph_q;
    first_d   = first_q;
    needed_d  = needed_q;
    out_d     = out_q;
    slemu_d   = slemu_q;
    count_d   = count_q;
    acc_d     = acc_q;
    vld_d     = 1'b0;
    a_d       = a_q;
    b_d       = b_q;
    w_d       = w_q;

    if (frame_start_i) begin
      state_d   = ST_CALC;
      calc_ph_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_CALC: begin
          if (!calc_ph_q) begin
            first_d   = vpos_1st_rdline_i;
            needed_d  = vlines_in_needed_i;
            out_d     = vlines_out_i;
            slemu_d   = v_allow_slemu_i;
            calc_ph_d = 1'b1;
          end else begin
            acc_d     = acc_init;
            count_d   = '0;
            calc_ph_d = 1'b0;
            state_d   = (out_q == '0 || needed_q == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (line_req_i) begin
            vld_d = 1'b1;
            if (acc_q[ACC_W-1]) begin
              a_d = first_q;
              b_d = first_q;
              w_d = '0;
            end else begin
              a_d = a_wide[LINE_W-1:0];
              b_d = (b_cand > last_line) ? last_line[LINE_W-1:0] : b_cand[LINE_W-1:0];
              w_d = acc_q[FRAC_BITS-1 -: WEIGHT_W];
            end
            acc_d   = acc_q + step_s;
            count_d = count_q + OUT_W'(1);
            if (count_d == out_q) state_d = ST_DONE;
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge VCLK) begin
    if (VRST) begin
      state_q   <= ST_IDLE;
      calc_ph_q <= 1'b0;
      first_q   <= '0;
      needed_q  <= '0;
      out_q     <= '0;
      slemu_q   <= 1'b0;
      count_q   <= '0;
      acc_q     <= '0;
      vld_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      w_q       <= '0;
    end else begin
      state_q   <= state_d;
      calc_ph_q <= calc_ph_d;
      first_q   <= first_d;
      needed_q  <= needed_d;
      out_q     <= out_d;
      slemu_q   <= slemu_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      vld_q     <= vld_d;
      a_q       <= a_d;
      b_q       <= b_d;
      w_q       <= w_d;
    end
  end

  assign line_vld_o   = vld_q;
  assign rdline_a_o   = a_q;
  assign rdline_b_o   = b_q;
  assign weight_b_o   = w_q;
  assign slemu_o      = slemu_q;
  assign frame_done_o = (state_q == ST_DONE);
  assign busy_o       = (state_q == ST_CALC);

endmodule

// File: tb/tb_scaler_vline_stepper.sv
module tb_scaler_vline_stepper;

  logic        VCLK = 1'b0;
  logic        VRST = 1'b1;
  logic [9:0]  vpos_1st_rdline_i = '0;
  logic [9:0]  vlines_in_needed_i = '0;
  logic [10:0] vlines_out_i = '0;
  logic [17:0] v_interp_factor_i = '0;
  logic        v_allow_slemu_i = 1'b0;
  logic        frame_start_i = 1'b0;
  logic        line_req_i = 1'b0;
  logic        line_vld_o;
  logic [9:0]  rdline_a_o, rdline_b_o;
  logic [7:0]  weight_b_o;
  logic        slemu_o, frame_done_o, busy_o;

  always #5 VCLK = ~VCLK;

  scaler_vline_stepper dut (
    .VCLK               (VCLK),
    .VRST               (VRST),
    .vpos_1st_rdline_i  (vpos_1st_rdline_i),
    .vlines_in_needed_i (vlines_in_needed_i),
    .vlines_out_i       (vlines_out_i),
    .v_interp_factor_i  (v_interp_factor_i),
    .v_allow_slemu_i    (v_allow_slemu_i),
    .frame_start_i      (frame_start_i),
    .line_req_i         (line_req_i),
    .line_vld_o         (line_vld_o),
    .rdline_a_o         (rdline_a_o),
    .rdline_b_o         (rdline_b_o),
    .weight_b_o         (weight_b_o),
    .slemu_o            (slemu_o),
    .frame_done_o       (frame_done_o),
    .busy_o             (busy_o)
  );

  int errors = 0;
  int checks = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Behavioural model: a frame is (config snapshot, closed-form phase per line index).
  // cfg_age: -1 idle, 0 frame_start seen, 1 config latched, 2 accepting lines.
  int     cfg_age = -1;
  int     c_first, c_needed, c_out;
  longint c_step, c_init;
  int     n_issued;
  logic   model_ready = 1'b0;
  logic   e_vld = 0, e_done = 0, e_busy = 0, e_slemu = 0, e_zero = 1;
  int     e_a = 0, e_b = 0, e_w = 0;

  task automatic line_vals(input int k, output int a, output int b, output int w);
    longint acc, ip, bb;
    acc = c_init + longint'(k) * c_step;
    if (acc < 0) begin
      a = c_first; b = c_first; w = 0;
    end else begin
      ip = acc / 131072;
      a  = int'((c_first + ip) % 1024);
      bb = c_first + ip + 1;
      if (bb > c_first + c_needed - 1) bb = c_first + c_needed - 1;
      b  = int'(bb % 1024);
      w  = int'((acc % 131072) / 512);
    end
  endtask

  task automatic model_update();
    int a, b, w;
    model_ready = 1'b1;
    if (VRST) begin
      cfg_age = -1; e_vld = 0; e_done = 0; e_busy = 0; e_slemu = 0; e_zero = 1;
      e_a = 0; e_b = 0; e_w = 0;
    end else if (frame_start_i) begin
      cfg_age = 0; e_vld = 0; e_done = 0; e_busy = 1;
    end else begin
      e_vld = 0;
      case (cfg_age)
        0: begin
          c_first  = int'(vpos_1st_rdline_i);
          c_needed = int'(vlines_in_needed_i);
          c_out    = int'(vlines_out_i);
          e_slemu  = v_allow_slemu_i;
          c_step   = longint'(v_interp_factor_i) * longint'(vlines_in_needed_i);
`ifdef SCALER_VSTEP_CENTER_EN
          c_init   = (c_step - 131072) >>> 1;
`else
          c_init   = 0;
`endif
          cfg_age  = 1;
        end
        1: begin
          cfg_age  = 2; e_busy = 0; n_issued = 0;
          e_done   = (c_out == 0 || c_needed == 0);
        end
        2: begin
          if (!e_done && line_req_i) begin
            line_vals(n_issued, a, b, w);
            e_a = a; e_b = b; e_w = w;
            e_vld = 1; e_zero = 0;
            n_issued++;
            if (n_issued == c_out) e_done = 1;
          end
        end
        default: ;
      endcase
    end
  endtask

  always @(negedge VCLK) begin
    if (model_ready) begin
      check("vld", line_vld_o, e_vld);
      check("done", frame_done_o, e_done);
      check("busy", busy_o, e_busy);
      check("slemu", slemu_o, e_slemu);
      if (e_vld || e_zero) begin
        check("rdline_a", rdline_a_o, e_a);
        check("rdline_b", rdline_b_o, e_b);
        check("weight_b", weight_b_o, e_w);
      end
    end
  end

  task automatic tick();
    @(posedge VCLK);
    model_update();
    #1;
  endtask

  task automatic set_cfg(input int f, input int nd, input int o, input int fac, input logic sl);
    vpos_1st_rdline_i  = 10'(f);
    vlines_in_needed_i = 10'(nd);
    vlines_out_i       = 11'(o);
    v_interp_factor_i  = 18'(fac);
    v_allow_slemu_i    = sl;
  endtask

  task automatic start_frame();
    frame_start_i = 1'b1; tick();
    frame_start_i = 1'b0; tick(); tick();
  endtask

  task automatic req();
    line_req_i = 1'b1; tick();
    line_req_i = 1'b0;
  endtask

  task automatic pin_line(input string name, input int a, input int b, input int w);
    check({name, "_vld"}, line_vld_o, 1);
    check({name, "_a"}, rdline_a_o, a);
    check({name, "_b"}, rdline_b_o, b);
    check({name, "_w"}, weight_b_o, w);
  endtask

  initial begin
    int budget;
    // reset
    repeat (3) tick();
    check("rst_vld", line_vld_o, 0);
    check("rst_a", rdline_a_o, 0);
    check("rst_b", rdline_b_o, 0);
    check("rst_w", weight_b_o, 0);
    check("rst_done", frame_done_o, 0);
    check("rst_busy", busy_o, 0);
    VRST = 1'b0;
    tick();

    // test 1/2: step = 128*240 = 30720
    set_cfg(0, 240, 1024, 128, 1'b1);
    start_frame();
    req();
`ifdef SCALER_VSTEP_CENTER_EN
    pin_line("t2_l0", 0, 0, 0);
    req(); pin_line("t2_l1", 0, 0, 0);
    req(); pin_line("t2_l2", 0, 1, 22);
    req(); req(); req(); pin_line("t2_l5", 0, 1, 202);
`else
    pin_line("t1_l0", 0, 1, 0);
    req(); pin_line("t1_l1", 0, 1, 60);
    req(); pin_line("t1_l2", 0, 1, 120);
    req(); req(); req(); pin_line("t1_l5", 1, 2, 44);
`endif
    repeat (100) begin
      line_req_i = ($urandom_range(0, 1) == 1);
      tick();
    end

    // test 4: config change mid-frame must not affect the running frame
    set_cfg(24, 240, 480, 273, 1'b0);
    budget = 4000;
    while (!frame_done_o && budget > 0) begin
      line_req_i = ($urandom_range(0, 3) != 0);
      tick();
      budget--;
    end
    line_req_i = 1'b0;
    check("t4_done_in_budget", frame_done_o, 1);
    check("t4_slemu_held", slemu_o, 1);

    // test 3: last line clamps b; one request past the end is ignored
    start_frame();
    line_req_i = 1'b1;
    repeat (479) tick();
    tick();
    line_req_i = 1'b0;
`ifdef SCALER_VSTEP_CENTER_EN
    pin_line("t3_last", 263, 263, 49);
`else
    pin_line("t3_last", 263, 263, 113);
`endif
    req();
    check("t3_extra_vld", line_vld_o, 0);
    check("t3_extra_done", frame_done_o, 1);

    // test 5: frame_start together with line_req mid-run
    set_cfg(5, 100, 200, 655, 1'b1);
    start_frame();
    req(); req(); req();
    frame_start_i = 1'b1; line_req_i = 1'b1; tick();
    frame_start_i = 1'b0; line_req_i = 1'b0;
    check("t5_vld", line_vld_o, 0);
    check("t5_busy1", busy_o, 1);
    tick(); check("t5_busy2", busy_o, 1);
    tick(); check("t5_busy_end", busy_o, 0);
    req();
`ifdef SCALER_VSTEP_CENTER_EN
    pin_line("t5_l0", 5, 5, 0);
`else
    pin_line("t5_l0", 5, 6, 0);
`endif

    // test 6: reset lands on an accepted request
    req();
    line_req_i = 1'b1; VRST = 1'b1; tick();
    check("t6_vld", line_vld_o, 0);
    check("t6_a", rdline_a_o, 0);
    check("t6_busy", busy_o, 0);
    check("t6_done", frame_done_o, 0);
    VRST = 1'b0; tick();
    check("t6_idle_vld", line_vld_o, 0);
    line_req_i = 1'b0;
    tick();

    // random frames, including empty configs and restarts mid-frame
    for (int fr = 0; fr < 10; fr++) begin
      int o, nd;
      o  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 300));
      nd = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1023));
      set_cfg(int'($urandom_range(0, 1023)), nd, o, (o == 0) ? 0 : 131072 / o,
              1'($urandom_range(0, 1)));
      frame_start_i = 1'b1; tick(); frame_start_i = 1'b0;
      for (int c = 0; c < 500; c++) begin
        line_req_i    = ($urandom_range(0, 3) != 0);
        frame_start_i = ($urandom_range(0, 299) == 0);
        tick();
      end
      line_req_i = 1'b0; frame_start_i = 1'b0;
    end
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
